// File: rtl/cis_line_scanner_core.sv
// cis_line_scanner_core
//   Timing and readout core for a contact-image-sensor line scanner. Generates
//   the sensor pixel clock (CLK/2), the start-of-line pulse and the R/G/B LED
//   enables. It captures one 12-bit offset-binary ADC sample per active pixel
//   and packs pixel pairs into 32-bit words for the downstream FIFO.
//
// Ports
//   CLK, RSTN            system clock, asynchronous active-low reset
//   SENSOR_RESET         synchronous soft reset (line counters are kept)
//   CIS_MODE             0 free-run, 1 encoder-triggered, 2/3 halted
//   LINES_DELAY          free-run line period in sensor clocks
//   R_ON/G_ON/B_ON       LED on-time per line in sensor clocks
//   ENCODER_EVENT        asynchronous encoder level, each toggle is a trigger
//   WR_AFULL             downstream almost-full, sampled at start of line
//   DC                   ADC sample
//   CLKC, SIC, LRGB      sensor clock, start-of-line pulse, LED enables
//   PIXELS_OUT/DV        packed pixel pair and its one-cycle valid
//   LINE_CNT, DROP_CNT   completed / discarded line counters (wrapping)
module cis_line_scanner_core #(
  parameter int unsigned PIXELS       = 2592,
  parameter int unsigned DUMMY_PIXELS = 89
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        SENSOR_RESET,
  input  logic [1:0]  CIS_MODE,
  input  logic [23:0] LINES_DELAY,
  input  logic [23:0] R_ON,
  input  logic [23:0] G_ON,
  input  logic [23:0] B_ON,
  input  logic        ENCODER_EVENT,
  input  logic        WR_AFULL,
  input  logic [11:0] DC,
  output logic        CLKC,
  output logic        SIC,
  output logic [2:0]  LRGB,
  output logic [31:0] PIXELS_OUT,
  output logic        PIXELS_DV,
  output logic [15:0] LINE_CNT,
  output logic [15:0] DROP_CNT
);

  localparam logic [23:0] DUMMY_END   = 24'(DUMMY_PIXELS);
  localparam logic [23:0] ACTIVE_LAST = 24'(DUMMY_PIXELS + PIXELS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SI,
    S_DUMMY,
    S_ACTIVE,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        clkc_q, clkc_d;
  logic [23:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]  led_q, led_d;
  logic [2:0]  enc_s_q, enc_s_d;
  logic        pend_q, pend_d;
  logic        drop_q, drop_d;
  logic        half_q, half_d;
  logic [15:0] lo_q, lo_d;
  logic [31:0] pix_q, pix_d;
  logic        dv_q, dv_d;
  logic [15:0] line_cnt_q, line_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  logic        tick, fall, enc_edge, start;
  logic [23:0] tick_inc;
  logic [15:0] pixel;

  always_comb begin
    state_d    = state_q;
    clkc_d     = ~clkc_q;
    tick_cnt_d = tick_cnt_q;
    led_d      = led_q;
    enc_s_d    = {enc_s_q[1:0], ENCODER_EVENT};
    pend_d     = pend_q;
    drop_d     = drop_q;
    half_d     = half_q;
    lo_d       = lo_q;
    pix_d      = pix_q;
    dv_d       = 1'b0;
    line_cnt_d = line_cnt_q;
    drop_cnt_d = drop_cnt_q;

    tick     = ~clkc_q;
    fall     = clkc_q;
    enc_edge = enc_s_q[2] ^ enc_s_q[1];
    pixel    = {4'h0, DC ^ 12'h800};
    // tick_cnt is both the position within the line and the free-run period
    // timer; it saturates so long idle gaps never wrap into a false start.
    tick_inc = (&tick_cnt_q) ? tick_cnt_q : tick_cnt_q + 24'd1;
    start    = ((CIS_MODE == 2'd0) && (tick_inc >= LINES_DELAY)) ||
               ((CIS_MODE == 2'd1) && pend_q);

    if (tick) begin
      tick_cnt_d = tick_inc;
      // LEDs only ever turn off between start pulses
      led_d = led_q & {(B_ON > tick_inc), (G_ON > tick_inc), (R_ON > tick_inc)};
    end

    case (state_q)
      S_IDLE: begin
        if (tick && start) begin
          state_d    = S_SI;
          tick_cnt_d = '0;
          led_d      = {(B_ON != '0), (G_ON != '0), (R_ON != '0)};
          pend_d     = 1'b0;
          drop_d     = WR_AFULL;
          half_d     = 1'b0;
        end
      end
      S_SI: begin
        if (tick) state_d = (DUMMY_PIXELS > 1) ? S_DUMMY : S_ACTIVE;
      end
      S_DUMMY: begin
        if (tick && (tick_inc == DUMMY_END)) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (fall) begin
          if (!drop_q) begin
            if (!half_q) begin
              lo_d = pixel;
            end else begin
              pix_d = {pixel, lo_q};
              dv_d  = 1'b1;
            end
          end
          half_d = ~half_q;
          if (tick_cnt_q == ACTIVE_LAST) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d    = S_IDLE;
        line_cnt_d = line_cnt_q + 16'd1;
        if (drop_q) drop_cnt_d = drop_cnt_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // an edge coinciding with the start pulse still counts as a new trigger
    if (enc_edge) pend_d = 1'b1;

    if (SENSOR_RESET) begin
      state_d    = S_IDLE;
      clkc_d     = 1'b0;
      tick_cnt_d = '0;
      led_d      = '0;
      pend_d     = 1'b0;
      half_d     = 1'b0;
      dv_d       = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= S_IDLE;
      clkc_q     <= 1'b0;
      tick_cnt_q <= '0;
      led_q      <= '0;
      enc_s_q    <= '0;
      pend_q     <= 1'b0;
      drop_q     <= 1'b0;
      half_q     <= 1'b0;
      lo_q       <= '0;
      pix_q      <= '0;
      dv_q       <= 1'b0;
      line_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      clkc_q     <= clkc_d;
      tick_cnt_q <= tick_cnt_d;
      led_q      <= led_d;
      enc_s_q    <= enc_s_d;
      pend_q     <= pend_d;
      drop_q     <= drop_d;
      half_q     <= half_d;
      lo_q       <= lo_d;
      pix_q      <= pix_d;
      dv_q       <= dv_d;
      line_cnt_q <= line_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign CLKC       = clkc_q;
  assign SIC        = (state_q == S_SI);
  assign LRGB       = led_q;
  assign PIXELS_OUT = pix_q;
  assign PIXELS_DV  = dv_q;
  assign LINE_CNT   = line_cnt_q;
  assign DROP_CNT   = drop_cnt_q;

endmodule

// File: tb/tb_cis_line_scanner_core.sv
// tb_cis_line_scanner_core
//   Scoreboard bench: a sensor model drives DC per active pixel and queues the
//   packed word it expects; a monitor pops and compares on every PIXELS_DV.
module tb_cis_line_scanner_core;

  localparam int D = 89;
  localparam int P = 2592;

  logic        CLK, RSTN, SENSOR_RESET, ENCODER_EVENT, WR_AFULL;
  logic [1:0]  CIS_MODE;
  logic [23:0] LINES_DELAY, R_ON, G_ON, B_ON;
  logic [11:0] DC;
  logic        CLKC, SIC, PIXELS_DV;
  logic [2:0]  LRGB;
  logic [31:0] PIXELS_OUT;
  logic [15:0] LINE_CNT, DROP_CNT;

  cis_line_scanner_core #(.PIXELS(P), .DUMMY_PIXELS(D)) dut (
    .CLK(CLK), .RSTN(RSTN), .SENSOR_RESET(SENSOR_RESET), .CIS_MODE(CIS_MODE),
    .LINES_DELAY(LINES_DELAY), .R_ON(R_ON), .G_ON(G_ON), .B_ON(B_ON),
    .ENCODER_EVENT(ENCODER_EVENT), .WR_AFULL(WR_AFULL), .DC(DC),
    .CLKC(CLKC), .SIC(SIC), .LRGB(LRGB), .PIXELS_OUT(PIXELS_OUT),
    .PIXELS_DV(PIXELS_DV), .LINE_CNT(LINE_CNT), .DROP_CNT(DROP_CNT)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dv_cnt = 0;
  int si_cnt = 0;
  logic [31:0] first_word, last_word;
  logic [31:0] exp_q[$];
  bit live = 0;
  bit drop_line = 0;
  bit sic_prev = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc++;

  // sensor model: ADC output changes after each pixel-clock rise
  initial begin
    int k;
    logic [11:0] val, prev_val;
    k = 0; prev_val = '0; DC = '0;
    forever begin
      @(posedge CLKC);
      #1;
      if (SIC) begin
        k = 0; live = 1; drop_line = WR_AFULL;
      end else if (live) begin
        k++;
      end
      if (live && k >= D && k <= D + P - 1) begin
        val = 12'(k - D + 1);
        DC = val ^ 12'h800;
        if ((((k - D) % 2) == 1) && !drop_line)
          exp_q.push_back({4'h0, val, 4'h0, prev_val});
        prev_val = val;
        if (k == D + P - 1) live = 0;
      end else begin
        DC = 12'h3C3;
      end
    end
  end

  // monitor
  always @(negedge CLK) begin
    if (RSTN) begin
      if (SIC && !sic_prev) si_cnt++;
      sic_prev = SIC;
      if (PIXELS_DV) begin
        check_eq("dv_queued", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check_eq("word", PIXELS_OUT, exp_q.pop_front());
        if (dv_cnt == 0) first_word = PIXELS_OUT;
        last_word = PIXELS_OUT;
        dv_cnt++;
      end
    end else begin
      sic_prev = 0;
    end
  end

  task automatic wait_si(input int budget);
    int n = 0;
    while (!SIC && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check_eq("si_wait", 32'(SIC), 32'd1);
  endtask

  task automatic wait_lines(input logic [15:0] target, input int budget);
    int n = 0;
    while (LINE_CNT != target && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check_eq("line_cnt", 32'(LINE_CNT), 32'(target));
  endtask

  // called at the first cycle SIC is seen high
  task automatic measure_line_start();
    int r = 0, g = 0, b = 0, s = 0, c = 0;
    for (int i = 0; i < 60; i++) begin
      r += int'(LRGB[0]); g += int'(LRGB[1]); b += int'(LRGB[2]);
      s += int'(SIC); c += int'(CLKC);
      @(negedge CLK);
    end
    check_eq("led_r_cycles", 32'(r), 32'd10);
    check_eq("led_g_cycles", 32'(g), 32'd30);
    check_eq("led_b_cycles", 32'(b), 32'd0);
    check_eq("sic_cycles", 32'(s), 32'd2);
    check_eq("clkc_high_cycles", 32'(c), 32'd30);
  endtask

  task automatic toggle_enc();
    @(negedge CLK);
    ENCODER_EVENT = ~ENCODER_EVENT;
  endtask

  initial begin
    int t1, base, n;
    RSTN = 0; SENSOR_RESET = 0; CIS_MODE = 2'd2; LINES_DELAY = 24'd100;
    R_ON = 24'd5; G_ON = 24'd15; B_ON = 24'd0;
    ENCODER_EVENT = 0; WR_AFULL = 0;
    #1;
    check_eq("rst_ctl", {27'd0, CLKC, SIC, LRGB}, 32'd0);
    check_eq("rst_cnt", {LINE_CNT, DROP_CNT}, 32'd0);
    repeat (3) @(negedge CLK);
    RSTN = 1;

    // free-run: first line quickly, then a 10000-tick period
    CIS_MODE = 2'd0;
    wait_si(400);
    t1 = cyc;
    dv_cnt = 0;
    LINES_DELAY = 24'd10000;
    measure_line_start();
    wait_lines(16'd1, 6000);
    check_eq("l1_words", 32'(dv_cnt), 32'd1296);
    check_eq("l1_first", first_word, 32'h0002_0001);
    check_eq("l1_last", last_word, 32'h0A20_0A1F);
    wait_si(21000);
    check_eq("si_period", 32'(cyc - t1), 32'd20000);
    CIS_MODE = 2'd2;
    dv_cnt = 0;
    wait_lines(16'd2, 6000);
    check_eq("l2_words", 32'(dv_cnt), 32'd1296);
    check_eq("l2_last", last_word, 32'h0A20_0A1F);

    // encoder-triggered
    CIS_MODE = 2'd1;
    base = si_cnt;
    repeat (3000) @(negedge CLK);
    check_eq("m1_no_trigger", 32'(si_cnt - base), 32'd0);
    toggle_enc();
    repeat (7000) @(negedge CLK);
    check_eq("m1_one_si", 32'(si_cnt - base), 32'd1);
    toggle_enc();
    repeat (2000) @(negedge CLK);
    toggle_enc();
    repeat (500) @(negedge CLK);
    toggle_enc();
    repeat (10000) @(negedge CLK);
    check_eq("m1_merged_si", 32'(si_cnt - base), 32'd3);
    check_eq("m1_lines", 32'(LINE_CNT), 32'd5);

    // overflow drop, then recovery
    WR_AFULL = 1;
    dv_cnt = 0;
    toggle_enc();
    wait_si(100);
    measure_line_start();
    WR_AFULL = 0;
    wait_lines(16'd6, 6000);
    check_eq("drop_words", 32'(dv_cnt), 32'd0);
    check_eq("drop_cnt", 32'(DROP_CNT), 32'd1);
    dv_cnt = 0;
    toggle_enc();
    wait_si(100);
    wait_lines(16'd7, 6000);
    check_eq("recover_words", 32'(dv_cnt), 32'd1296);
    check_eq("drop_cnt_kept", 32'(DROP_CNT), 32'd1);

    // soft reset mid-active
    dv_cnt = 0;
    toggle_enc();
    wait_si(100);
    repeat (3000) @(negedge CLK);
    check_eq("sr_dv_before", 32'(dv_cnt > 500), 32'd1);
    SENSOR_RESET = 1;
    repeat (2) @(negedge CLK);
    check_eq("sr_ctl", {27'd0, CLKC, SIC, LRGB, PIXELS_DV}, 32'd0);
    live = 0;
    exp_q.delete();
    SENSOR_RESET = 0;
    n = dv_cnt;
    base = si_cnt;
    repeat (200) @(negedge CLK);
    check_eq("sr_dv_stopped", 32'(dv_cnt), 32'(n));
    check_eq("sr_line_cnt", 32'(LINE_CNT), 32'd7);
    check_eq("sr_no_si", 32'(si_cnt - base), 32'd0);
    dv_cnt = 0;
    toggle_enc();
    wait_si(100);
    wait_lines(16'd8, 6000);
    check_eq("sr_next_words", 32'(dv_cnt), 32'd1296);
    check_eq("sr_next_first", first_word, 32'h0002_0001);
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

    // asynchronous hard reset mid-line
    toggle_enc();
    wait_si(100);
    repeat (500) @(negedge CLK);
    @(posedge CLK);
    #3;
    RSTN = 0;
    #1;
    check_eq("arst_ctl", {27'd0, CLKC, SIC, LRGB, PIXELS_DV}, 32'd0);
    check_eq("arst_pix", PIXELS_OUT, 32'd0);
    check_eq("arst_cnt", {LINE_CNT, DROP_CNT}, 32'd0);
    live = 0;
    exp_q.delete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cis_line_scanner_core.md
Name: cis_line_scanner_core

Overview:
- Timing and readout core for a contact-image-sensor (CIS) line scanner.
- Generates the sensor clock, the start-of-line pulse (SI) and the R/G/B LED enables.
- Captures 12-bit offset-binary ADC samples for each line and packs them as 16-bit pixels, two per 32-bit word, for the downstream pixel FIFO/DMA path.
- Lines are free-running at a programmed period, or triggered by an encoder.

Parameters:
- PIXELS, 2592, active pixels per line; must be even.
- DUMMY_PIXELS, 89, sensor clock periods between SI and the first active pixel.

Ports:
- CLK  in  1  system clock; all logic is synchronous to it.
- RSTN  in  1  asynchronous active-low reset.
- SENSOR_RESET  in  1  synchronous active-high soft reset.
- CIS_MODE  in  2  0 = free-run, 1 = encoder-triggered, 2/3 = halted.
- LINES_DELAY  in  24  free-run line period, in sensor clock periods.
- R_ON, G_ON, B_ON  in  24 each  LED on-duration per line, in sensor clock periods.
- ENCODER_EVENT  in  1  asynchronous level; each toggle is one trigger.
- WR_AFULL  in  1  downstream FIFO almost-full.
- DC  in  12  ADC sample, offset binary.
- CLKC  out  1  sensor pixel clock.
- SIC  out  1  sensor start-of-line pulse.
- LRGB  out  3  LED enables: [0]=R, [1]=G, [2]=B.
- PIXELS_OUT  out  32  packed pixel pair.
- PIXELS_DV  out  1  one-cycle valid for PIXELS_OUT.
- LINE_CNT  out  16  completed lines, wrapping.
- DROP_CNT  out  16  lines discarded on WR_AFULL, wrapping.

Behaviour:
- Reset:
  - RSTN low resets every output and counter to 0.
  - SENSOR_RESET returns the FSM to IDLE, drives CLKC/SIC/LRGB/PIXELS_DV to 0, clears any pending trigger, clears the free-run timer and discards a half-packed pair; LINE_CNT and DROP_CNT are kept.
  - Either reset mid-line aborts the line; the line is not counted.
- Sensor clock: CLKC toggles every CLK cycle whenever not in reset (f = fCLK/2). A "tick" is a CLK edge where CLKC goes 0→1.
- FSM states:
  - IDLE → SI: on a start condition, at the next tick.
  - SI: SIC high for one full CLKC period; that tick is tick 0.
  - DUMMY: ticks 1..DUMMY_PIXELS-1.
  - ACTIVE: ticks DUMMY_PIXELS .. DUMMY_PIXELS+PIXELS-1.
  - DONE: one CLK cycle; LINE_CNT++; return to IDLE.
- Sampling and packing:
  - For active tick k, DC is captured on the CLK cycle where CLKC falls after that tick.
  - pixel = {4'h0, DC ^ 12'h800}.
  - Even pixel goes to PIXELS_OUT[15:0]; the following odd pixel goes to [31:16].
  - PIXELS_DV pulses one cycle after the odd pixel is captured.
  - Result: PIXELS/2 words per line; data is held between pulses.
- LEDs:
  - LRGB[i] is high from tick 0 for X_ON ticks, then low until the next SI.
  - X_ON = 0 keeps that LED off.
  - X_ON ≥ line length keeps it on for the whole line.
- Mode 0 start condition:
  - A period counter reloads at each SI.
  - The next line starts when LINES_DELAY ticks have elapsed and the FSM is IDLE.
  - If LINES_DELAY is shorter than the line, lines run back-to-back.
- Mode 1 start condition:
  - ENCODER_EVENT is 2-FF synchronised; any edge sets a pending flag.
  - Pending is cleared on SI.
  - Edges arriving while pending or while a line is busy merge into one pending trigger.
- Modes 2/3: no lines start; any line in progress completes.
- Mode changes take effect only in IDLE.
- Overflow handling:
  - WR_AFULL is sampled at SI.
  - If high, the line is still clocked out to the sensor, PIXELS_DV is suppressed for the whole line and DROP_CNT++. LINE_CNT still increments.
  - WR_AFULL changes mid-line are ignored.

Test Plan:
1. Reset, then mode 0, LINES_DELAY=10000, DC = i^0x800 for active pixel i = 1..2592 → 1296 DV pulses per line; first word 0x0002_0001, last 0x0A20_0A1F. SI period is 10000 CLKC periods (20000 CLK cycles), and LINE_CNT increments per line.
2. R_ON=5, G_ON=15, B_ON=0 → LRGB[0] high for exactly 5 CLKC periods and LRGB[1] for 15, both starting at tick 0; LRGB[2] stays 0.
3. Mode 1, encoder toggling every 10000 CLK cycles → exactly one SI per toggle; no SI without a toggle. Two toggles during one busy line → exactly one extra line.
4. WR_AFULL=1 at SI → SIC/CLKC/LRGB behave normally, zero DV pulses, DROP_CNT=1. WR_AFULL deasserted before the next SI → the next line yields 1296 words.
5. SENSOR_RESET pulsed mid-ACTIVE → DV stops and CLKC/SIC/LRGB go low with LINE_CNT unchanged. The next line packs from pixel 0 and yields 1296 words.
6. RSTN asserted asynchronously (no CLK edge) → all outputs read 0 immediately.
